alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Downstream stage of the ALU logic unit. It captures each ALU result beat (data, compare flags, opcode, destination register) into a 2-entry elastic buffer with valid/ready handshakes on both sides. Beats leave in order toward register-file writeback. As each compare beat commits, the stage updates the architectural status-flag register that branch logic reads.

## Interface
Parameters:
- DATA_WIDTH, default CPU_package::DATA_WIDTH: result width.
- REG_ADDR_WIDTH, default CPU_package::REG_ADDR_WIDTH: destination register index width.

Ports:
- clk, input, 1: single clock; all state is updated on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: upstream beat present.
- in_ready, output, 1: stage can accept a beat.
- in_opcode, input, enum_alu_opcode_t: opcode of the beat.
- in_result, input, DATA_WIDTH: logic result.
- in_flag, input, 3: compare flags {EQ,GT,LT}.
- in_dest, input, REG_ADDR_WIDTH: destination register.
- out_valid, output, 1: head beat present.
- out_ready, input, 1: writeback accepts the head beat.
- out_result, output, DATA_WIDTH: head result.
- out_dest, output, REG_ADDR_WIDTH: head destination.
- out_we, output, 1: head beat writes a register.
- flag_clr, input, 1: synchronous clear of the status flags.
- status_flag, output, 3: committed {EQ,GT,LT}.
- flag_valid, output, 1: status_flag holds a committed compare.
- flag_err, output, 1: sticky; set by a malformed compare.

## Operation
- Input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- Buffer: 2 entries, FIFO order, occupancy count 0..2.
  - in_ready = (count < 2), forced 0 while rst_n is low.
  - out_valid = (count > 0).
- Entry contents: opcode, result, flag, dest.
  - out_we = 1 for ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR and ALU_OP_NOT.
  - out_we = 0 for ALU_OP_CPR and for any other encoding.
  - For out_we = 0 entries, out_result and out_dest are driven but don't-care.
- Flag commit on the output transfer of an ALU_OP_CPR entry:
  - If the entry flag is exactly one of 3'b100 (EQ), 3'b010 (GT) or 3'b001 (LT): status_flag is loaded with it and flag_valid is set to 1.
  - Otherwise: status_flag is set to 3'b000, flag_valid to 0, and flag_err to 1.
- flag_err is cleared only by reset.
- flag_clr: status_flag is set to 0 and flag_valid to 0. It takes priority over a same-cycle CPR commit, but that commit still sets flag_err if its flag is malformed.
- Flags update on commit, not on acceptance, so buffered compares never affect status_flag early.
- Beats in the buffer do not mix: each output field comes from the head entry only.

## Timing
- Reset values: in_ready=0 while reset is asserted, 1 after release. out_valid, out_result, out_dest, out_we, status_flag, flag_valid and flag_err are all 0. Count is 0.
- Latency: a beat accepted at edge N is visible on out_* after edge N (1 cycle) when the buffer was empty.
- Throughput is 1 beat/cycle when out_ready is held high. Simultaneous push and pop at count 1 keeps count at 1. Push and pop at count 2 cannot occur, because in_ready is 0.
- Full (count 2): in_ready drops in the cycle after the second acceptance and returns the cycle after a pop.
- Empty: out_valid is 0 and out_we is 0.
- out_* hold stable while out_valid && !out_ready.
- Reset asserted mid-operation: the buffer is flushed immediately. Buffered CPR beats are discarded and do not commit. flag_err is cleared.
- status_flag and flag_valid change only on the edge of the commit or clear.

## Structure
- CPU_package gains:
  - REG_ADDR_WIDTH;
  - ALU_FLAG_EQ = 3'b100, ALU_FLAG_GT = 3'b010, ALU_FLAG_LT = 3'b001;
  - typedef struct packed alu_result_t {opcode, result, flag, dest}.
- Sub-module alu_result_fifo: generic 2-entry alu_result_t FIFO with valid/ready on both sides and the same clk/rst_n.
- The top level adds out_we decode, the flag register, the flag_clr/commit priority and flag_err.

## Test plan
- Reset then single AND: in_result=16'h00F0, dest=3 -> out_valid next cycle, out_result=16'h00F0, out_dest=3, out_we=1.
- CPR with flag=3'b010 and out_ready=1 -> out_we=0; after commit, status_flag=3'b010 and flag_valid=1.
- Stall: out_ready=0 while sending three beats (XOR, OR, NOT) -> two are accepted, then in_ready=0. On releasing out_ready, outputs appear in order XOR, OR, NOT with no loss or duplication.
- Malformed CPR, flag=3'b110 -> status_flag=0, flag_valid=0, flag_err=1. A later valid CPR EQ gives status_flag=3'b100 while flag_err stays 1.
- flag_clr in the same cycle as a CPR LT commit -> status_flag=0 and flag_valid=0 on the next edge.
- rst_n pulsed low with two CPR beats buffered -> out_valid=0 immediately and status_flag unchanged at 0; no commit after release.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
// Shared CPU types and constants for the ALU result path: opcode encoding,
// compare-flag codes, the buffered result beat and small decode helpers.
package CPU_package;

  localparam int DATA_WIDTH     = 16;
  localparam int REG_ADDR_WIDTH = 5;

  // Encodings 5..7 are unassigned and treated as non-writing, non-compare.
  typedef enum logic [2:0] {
    ALU_OP_AND = 3'd0,
    ALU_OP_OR  = 3'd1,
    ALU_OP_XOR = 3'd2,
    ALU_OP_NOT = 3'd3,
    ALU_OP_CPR = 3'd4
  } enum_alu_opcode_t;

  localparam logic [2:0] ALU_FLAG_EQ = 3'b100;
  localparam logic [2:0] ALU_FLAG_GT = 3'b010;
  localparam logic [2:0] ALU_FLAG_LT = 3'b001;

  typedef struct packed {
    enum_alu_opcode_t            opcode;
    logic [DATA_WIDTH-1:0]       result;
    logic [2:0]                  flag;
    logic [REG_ADDR_WIDTH-1:0]   dest;
  } alu_result_t;

  // Logic ops produce a register result; compares and unknown codes do not.
  function automatic logic is_write_op(input enum_alu_opcode_t op);
    logic we;
    unique case (op)
      ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_NOT: we = 1'b1;
      default:                                       we = 1'b0;
    endcase
    return we;
  endfunction

  // A well-formed compare reports exactly one of EQ, GT, LT.
  function automatic logic flag_is_legal(input logic [2:0] flag);
    return (flag == ALU_FLAG_EQ) || (flag == ALU_FLAG_GT) || (flag == ALU_FLAG_LT);
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Two-entry elastic buffer with valid/ready on both sides. Entries leave in
// the order they arrived; the head entry is presented on out_data.
module alu_result_fifo
  import CPU_package::*;
#(
  parameter type entry_t = alu_result_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_data
);

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // Not ready while reset is held so no beat is taken into a flushing buffer.
  assign in_ready  = rst_n && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage, pointers and occupancy; a reset flushes every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      // NOTE: the two entries are reset so the head fields read as zero after
      // reset; this is cheap at depth 2 and would not be done for a RAM.
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees the
      // pre-edge values of the others regardless of statement order.
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers result beats toward register writeback, decodes
// the write enable of the head beat and maintains the architectural status
// flags, updated only when a compare beat leaves the buffer.
module alu_result_stage
  import CPU_package::*;
#(
  parameter int DATA_WIDTH     = CPU_package::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = CPU_package::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  enum_alu_opcode_t          in_opcode,
  input  logic [DATA_WIDTH-1:0]     in_result,
  input  logic [2:0]                in_flag,
  input  logic [REG_ADDR_WIDTH-1:0] in_dest,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic [REG_ADDR_WIDTH-1:0] out_dest,
  output logic                      out_we,
  input  logic                      flag_clr,
  output logic [2:0]                status_flag,
  output logic                      flag_valid,
  output logic                      flag_err
);

  // Same layout as alu_result_t but sized by this instance's parameters.
  typedef struct packed {
    enum_alu_opcode_t            opcode;
    logic [DATA_WIDTH-1:0]       result;
    logic [2:0]                  flag;
    logic [REG_ADDR_WIDTH-1:0]   dest;
  } entry_t;

  entry_t in_entry;
  entry_t head;
  logic   commit_cpr;
  logic   commit_ok;

  assign in_entry = '{opcode: in_opcode, result: in_result, flag: in_flag, dest: in_dest};

  alu_result_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  // Every output field comes from the head entry alone.
  assign out_result = head.result;
  assign out_dest   = head.dest;
  assign out_we     = out_valid && is_write_op(head.opcode);

  // A compare commits when it leaves the buffer, never when it is accepted.
  assign commit_cpr = out_valid && out_ready && (head.opcode == ALU_OP_CPR);
  assign commit_ok  = flag_is_legal(head.flag);

  // Status flags: clear wins over a same-cycle commit; malformed compares
  // still raise the sticky error even when the clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_flag <= 3'b000;
      flag_valid  <= 1'b0;
      flag_err    <= 1'b0;
    end else begin
      if (commit_cpr && !commit_ok) begin
        flag_err <= 1'b1;
      end
      if (flag_clr) begin
        status_flag <= 3'b000;
        flag_valid  <= 1'b0;
      end else if (commit_cpr) begin
        if (commit_ok) begin
          status_flag <= head.flag;
          flag_valid  <= 1'b1;
        end else begin
          status_flag <= 3'b000;
          flag_valid  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: reset state, latency, compare commit,
// back-pressure ordering, malformed compares, clear priority and mid-run reset.
module tb_alu_result_stage;
  import CPU_package::*;

  logic                      clk;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  enum_alu_opcode_t          in_opcode;
  logic [DATA_WIDTH-1:0]     in_result;
  logic [2:0]                in_flag;
  logic [REG_ADDR_WIDTH-1:0] in_dest;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_result;
  logic [REG_ADDR_WIDTH-1:0] out_dest;
  logic                      out_we;
  logic                      flag_clr;
  logic [2:0]                status_flag;
  logic                      flag_valid;
  logic                      flag_err;

  int n_checks = 0;
  int n_errors = 0;

  alu_result_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_result   (in_result),
    .in_flag     (in_flag),
    .in_dest     (in_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_dest    (out_dest),
    .out_we      (out_we),
    .flag_clr    (flag_clr),
    .status_flag (status_flag),
    .flag_valid  (flag_valid),
    .flag_err    (flag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and return just after the edge that accepted it.
  task automatic push(input enum_alu_opcode_t op, input logic [15:0] res,
                      input logic [2:0] flag, input logic [4:0] dest);
    int waited;
    in_valid  = 1'b1;
    in_opcode = op;
    in_result = res;
    in_flag   = flag;
    in_dest   = dest;
    waited    = 0;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    check("push_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = ALU_OP_AND;
    in_result = '0;
    in_flag   = 3'b000;
    in_dest   = '0;
    out_ready = 1'b0;
    flag_clr  = 1'b0;

    // Reset state while reset is asserted.
    #2;
    check("rst_in_ready",    {31'd0, in_ready},    32'd0);
    check("rst_out_valid",   {31'd0, out_valid},   32'd0);
    check("rst_out_we",      {31'd0, out_we},      32'd0);
    check("rst_out_result",  {16'd0, out_result},  32'd0);
    check("rst_out_dest",    {27'd0, out_dest},    32'd0);
    check("rst_status_flag", {29'd0, status_flag}, 32'd0);
    check("rst_flag_valid",  {31'd0, flag_valid},  32'd0);
    check("rst_flag_err",    {31'd0, flag_err},    32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Single AND: visible one cycle after acceptance.
    out_ready = 1'b1;
    push(ALU_OP_AND, 16'h00F0, 3'b000, 5'd3);
    check("and_out_valid",  {31'd0, out_valid},  32'd1);
    check("and_out_result", {16'd0, out_result}, 32'h00F0);
    check("and_out_dest",   {27'd0, out_dest},   32'd3);
    check("and_out_we",     {31'd0, out_we},     32'd1);
    step();
    check("and_drained_valid", {31'd0, out_valid}, 32'd0);
    check("and_drained_we",    {31'd0, out_we},    32'd0);

    // CPR GT: flags wait for the commit edge.
    push(ALU_OP_CPR, 16'h1234, ALU_FLAG_GT, 5'd7);
    check("cpr_gt_we",          {31'd0, out_we},      32'd0);
    check("cpr_gt_pre_status",  {29'd0, status_flag}, 32'd0);
    check("cpr_gt_pre_fvalid",  {31'd0, flag_valid},  32'd0);
    step();
    check("cpr_gt_status", {29'd0, status_flag}, 32'b010);
    check("cpr_gt_fvalid", {31'd0, flag_valid},  32'd1);
    check("cpr_gt_err",    {31'd0, flag_err},    32'd0);

    // Back-pressure: two beats fit, the third waits; order is preserved.
    out_ready = 1'b0;
    push(ALU_OP_XOR, 16'h1111, 3'b000, 5'd1);
    push(ALU_OP_OR,  16'h2222, 3'b000, 5'd2);
    check("full_in_ready",   {31'd0, in_ready},   32'd0);
    check("full_head_xor",   {16'd0, out_result}, 32'h1111);
    in_valid  = 1'b1;
    in_opcode = ALU_OP_NOT;
    in_result = 16'h3333;
    in_flag   = 3'b000;
    in_dest   = 5'd4;
    step();
    check("stall_in_ready",  {31'd0, in_ready},   32'd0);
    check("stall_hold_res",  {16'd0, out_result}, 32'h1111);
    check("stall_hold_dest", {27'd0, out_dest},   32'd1);
    check("stall_hold_we",   {31'd0, out_we},     32'd1);
    out_ready = 1'b1;
    step();
    check("drain1_or_res",  {16'd0, out_result}, 32'h2222);
    check("drain1_or_dest", {27'd0, out_dest},   32'd2);
    check("drain1_ready",   {31'd0, in_ready},   32'd1);
    step();
    in_valid = 1'b0;
    check("drain2_not_res",   {16'd0, out_result}, 32'h3333);
    check("drain2_not_dest",  {27'd0, out_dest},   32'd4);
    check("drain2_not_we",    {31'd0, out_we},     32'd1);
    check("drain2_not_valid", {31'd0, out_valid},  32'd1);
    step();
    check("drain3_empty", {31'd0, out_valid}, 32'd0);

    // Malformed CPR clears status and raises the sticky error.
    push(ALU_OP_CPR, 16'h0000, 3'b110, 5'd0);
    step();
    check("bad_status", {29'd0, status_flag}, 32'd0);
    check("bad_fvalid", {31'd0, flag_valid},  32'd0);
    check("bad_err",    {31'd0, flag_err},    32'd1);
    push(ALU_OP_CPR, 16'h0000, ALU_FLAG_EQ, 5'd0);
    step();
    check("eq_status",   {29'd0, status_flag}, 32'b100);
    check("eq_fvalid",   {31'd0, flag_valid},  32'd1);
    check("eq_err_kept", {31'd0, flag_err},    32'd1);

    // Unassigned opcode: no write, no flag effect.
    push(enum_alu_opcode_t'(3'd7), 16'hBEEF, ALU_FLAG_LT, 5'd9);
    check("op7_we",    {31'd0, out_we},    32'd0);
    check("op7_valid", {31'd0, out_valid}, 32'd1);
    step();
    check("op7_status", {29'd0, status_flag}, 32'b100);

    // flag_clr wins over a same-cycle LT commit.
    push(ALU_OP_CPR, 16'h0000, ALU_FLAG_LT, 5'd0);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("clr_status", {29'd0, status_flag}, 32'd0);
    check("clr_fvalid", {31'd0, flag_valid},  32'd0);
    check("clr_empty",  {31'd0, out_valid},   32'd0);

    // Mid-run reset flushes two buffered compares without committing them.
    out_ready = 1'b0;
    push(ALU_OP_CPR, 16'h0000, ALU_FLAG_EQ, 5'd0);
    push(ALU_OP_CPR, 16'h0000, ALU_FLAG_GT, 5'd0);
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid},   32'd0);
    check("mid_rst_in_ready",  {31'd0, in_ready},    32'd0);
    check("mid_rst_err",       {31'd0, flag_err},    32'd0);
    check("mid_rst_status",    {29'd0, status_flag}, 32'd0);
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    check("post_rst_status", {29'd0, status_flag}, 32'd0);
    check("post_rst_fvalid", {31'd0, flag_valid},  32'd0);
    check("post_rst_valid",  {31'd0, out_valid},   32'd0);
    check("post_rst_ready",  {31'd0, in_ready},    32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
